uart_cmd_rx: RTL
================

# uart_cmd_rx

UART receive path and host command decoder for the voltmeter: the opposite direction of the existing UART transmit path. It deserialises 8N1 frames from the PC on the `rx` pin at the same baud setting as the transmitter (19200 Bd at 65 MHz). It decodes short ASCII commands into a streaming enable and a 13-bit channel mask. Those outputs gate the transmit-side `uart_control` and the VGA channel display. The block sits in the 65 MHz domain beside the UART transmitter.

## Interface
Parameters:
- `DBIT`, 8, data bits per frame.
- `SB_TICK`, 16, oversampling ticks in the stop bit.
- `DVSR`, 212, clock cycles per oversampling tick (16 ticks per bit).
- `DVSR_BIT`, 9, width of the divider counter.

Ports (one clock; reset is synchronous and active-low):
- `clk`, input, 1: 65 MHz system clock.
- `rst`, input, 1: synchronous reset, active-low.
- `rx`, input, 1: asynchronous serial input, idle high.
- `rx_data`, output, 8: last received byte.
- `rx_valid`, output, 1: one-cycle pulse; `rx_data` is valid in the same cycle.
- `frame_err`, output, 1: one-cycle pulse when the stop bit samples low.
- `stream_en`, output, 1: streaming enable level.
- `ch_mask`, output, 13: channel enable mask; bit k corresponds to channel k (bcd[k]).
- `cmd_ack`, output, 1: one-cycle pulse when a mask command is accepted.
- `cmd_err`, output, 1: one-cycle pulse on a malformed command.

## Operation
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `stream_en`=0, `ch_mask`=13'h1FFF, `cmd_ack`=0, `cmd_err`=0. Synchroniser flops reset to 1; both FSMs reset to their idle states.
- `rx` passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- Tick generator:
  - Counter runs 0..DVSR-1 and wraps.
  - `tick` is asserted in the cycle where the count equals DVSR-1, so one tick every DVSR cycles.
- Receiver FSM: IDLE, START, DATA, STOP. Counters are `s` (tick counter, 4 bits) and `n` (bit counter).
  - IDLE: when synchronised rx=0, go to START with s=0.
  - START: on the tick where s=7 (mid start bit), go to DATA with s=0, n=0 if rx is still 0. Otherwise return to IDLE (glitch rejected, no pulses).
  - DATA: on the tick where s=15, shift rx into the MSB (LSB-first reception). If n=DBIT-1, go to STOP; otherwise n++.
  - STOP: on the tick where s=SB_TICK-1, check rx. If rx=1, latch `rx_data` and pulse `rx_valid`. If rx=0, pulse `frame_err` only; `rx_data` is unchanged. Return to IDLE in both cases.
- Command FSM: C_IDLE and C_MASK, advanced only on an `rx_valid` byte.
  - C_IDLE, 'S' (0x53): `stream_en`<=1.
  - C_IDLE, 'P' (0x50): `stream_en`<=0.
  - C_IDLE, 'M' (0x4D): go to C_MASK; clear the shadow register and the digit count.
  - C_IDLE, CR (0x0D) or LF (0x0A): ignored.
  - C_IDLE, any other byte: `cmd_err`.
  - C_MASK, hex digit (0-9, A-F, a-f): shadow <= {shadow[11:0], nibble}, count++. A 5th digit pulses `cmd_err` and returns to C_IDLE.
  - C_MASK, CR with count ≥ 1: `ch_mask`<=shadow[12:0], pulse `cmd_ack`, return to C_IDLE.
  - C_MASK, CR with count 0, or any other byte: pulse `cmd_err`, return to C_IDLE; `ch_mask` unchanged.
  - `frame_err` while in C_MASK: abort to C_IDLE and pulse `cmd_err`.
- `rx_valid` and `frame_err` are mutually exclusive. `cmd_ack` and `cmd_err` are mutually exclusive.

## Timing
- Bit period = 16×DVSR = 3392 cycles at the defaults.
- `rx_valid` is registered: it rises 1 cycle after the stop-bit tick.
- Command outputs (`stream_en`, `ch_mask`, `cmd_ack`, `cmd_err`) update 1 cycle after `rx_valid`.
- Back-to-back frames: the receiver re-arms in IDLE on the cycle after the stop tick, so a start bit immediately following a stop bit is accepted.
- Reset asserted mid-frame: on the next edge, every output returns to its reset value and both FSMs return to idle. After reset releases, an rx already low is treated as a new start edge.
- No flow control and no buffering: each byte is reported once via `rx_valid`, and a byte that arrives before the consumer reads `rx_data` overwrites it.

## Structure
- Shared header `_uart_macros.vh`: ASCII constants (`CMD_START` 0x53, `CMD_PAUSE` 0x50, `CMD_MASK` 0x4D, `CR`, `LF`) and `MASK_RESET` 13'h1FFF.
- Sub-module `uart_rx` contains the synchroniser, tick generator and receiver FSM, with ports `clk`, `rst`, `rx`, `dout`, `rx_done`, `frame_err`.
- `uart_cmd_rx` instantiates `uart_rx` and contains the command FSM.

## Test plan
- Send frame 0x53 -> `rx_valid` pulses with `rx_data`=0x53; `stream_en` rises 1 cycle later. Send 0x50 -> `stream_en`=0.
- Send "M0015\r" -> exactly one `cmd_ack` pulse, `ch_mask`=13'h0015, `cmd_err` never asserted.
- Send "M12G" -> `cmd_err` pulses on 'G'; `ch_mask` stays 13'h1FFF; a following "S" still sets `stream_en`.
- Send a frame with the stop bit held low -> `frame_err` pulses, no `rx_valid`, `rx_data` unchanged. Send a 1000-cycle low glitch -> no pulses and the receiver FSM is back in IDLE.
- Send two back-to-back frames 0xA5 then 0x5A with no idle gap -> two `rx_valid` pulses 10 bit periods apart with the correct data.
- Assert `rst`=0 mid-way through "M1F" -> all outputs at reset values; after release, "M3\r" yields `ch_mask`=13'h0003.

Source files
------------

// File: rtl/uart_cmd_rx_pkg.sv
// Shared constants, state encodings and helpers for the UART command receiver.
package uart_cmd_rx_pkg;

    localparam logic [7:0]  CMD_START  = 8'h53;
    localparam logic [7:0]  CMD_PAUSE  = 8'h50;
    localparam logic [7:0]  CMD_MASK   = 8'h4D;
    localparam logic [7:0]  CR         = 8'h0D;
    localparam logic [7:0]  LF         = 8'h0A;
    localparam logic [12:0] MASK_RESET = 13'h1FFF;

    localparam int unsigned MASK_W     = 13;
    localparam int unsigned DIGIT_W    = 3;
    localparam int unsigned MAX_DIGITS = 4;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic {
        C_IDLE,
        C_MASK
    } cmd_state_e;

    typedef struct packed {
        logic       ok;
        logic [3:0] val;
    } hex_t;

    // ASCII hex character to nibble; ok is low for anything that is not a hex digit.
    function automatic hex_t hex_decode(input logic [7:0] c);
        hex_t h;
        h.ok  = 1'b1;
        h.val = 4'd0;
        if (c >= 8'h30 && c <= 8'h39) begin
            h.val = 4'(c - 8'h30);
        end else if (c >= 8'h41 && c <= 8'h46) begin
            h.val = 4'(c - 8'h37);
        end else if (c >= 8'h61 && c <= 8'h66) begin
            h.val = 4'(c - 8'h57);
        end else begin
            h.ok = 1'b0;
        end
        return h;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: rx synchroniser, 16x oversampling tick generator and
// receive FSM with registered byte/done/framing-error outputs.
module uart_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int unsigned DBIT     = 8,
    parameter int unsigned SB_TICK  = 16,
    parameter int unsigned DVSR     = 212,
    parameter int unsigned DVSR_BIT = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done,
    output logic            frame_err
);

    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic [1:0]          sync_q;
    logic                rx_s;
    logic [DVSR_BIT-1:0] cnt_q, cnt_d;
    logic                tick_c;

    rx_state_e           state_q, state_d;
    logic [3:0]          s_q, s_d;
    logic [NW-1:0]       n_q, n_d;
    logic [DBIT-1:0]     b_q, b_d;
    logic [DBIT-1:0]     dout_q, dout_d;
    logic                done_q, done_d;
    logic                ferr_q, ferr_d;

    assign rx_s   = sync_q[1];
    assign tick_c = (cnt_q == DVSR_BIT'(DVSR - 1));
    assign cnt_d  = tick_c ? '0 : cnt_q + DVSR_BIT'(1);

    // Receive FSM next state; mid-start-bit check rejects short glitches.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d = RX_START;
                    s_d     = 4'd0;
                end
            end
            RX_START: begin
                if (tick_c) begin
                    if (s_q == 4'd7) begin
                        if (!rx_s) begin
                            state_d = RX_DATA;
                            s_d     = 4'd0;
                            n_d     = '0;
                        end else begin
                            state_d = RX_IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick_c) begin
                    if (s_q == 4'd15) begin
                        s_d = 4'd0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = RX_STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            RX_STOP: begin
                if (tick_c) begin
                    if (s_q == 4'(SB_TICK - 1)) begin
                        if (rx_s) begin
                            dout_d = b_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                        state_d = RX_IDLE;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            s_q     <= 4'd0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            cnt_q   <= cnt_d;
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign dout      = dout_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Host command receiver: decodes S / P / M<hex>CR commands from the UART
// into a streaming enable and a 13-bit channel mask.
module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int unsigned DBIT     = 8,
    parameter int unsigned SB_TICK  = 16,
    parameter int unsigned DVSR     = 212,
    parameter int unsigned DVSR_BIT = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DBIT-1:0]   rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              stream_en,
    output logic [MASK_W-1:0] ch_mask,
    output logic              cmd_ack,
    output logic              cmd_err
);

    logic [DBIT-1:0] rx_byte;
    logic            rx_done_w;
    logic            ferr_w;
    logic [7:0]      byte_c;
    hex_t            hex_c;

    cmd_state_e         cstate_q, cstate_d;
    logic               stream_q, stream_d;
    logic [MASK_W-1:0]  mask_q, mask_d;
    logic [MASK_W-1:0]  shadow_q, shadow_d;
    logic [DIGIT_W-1:0] digits_q, digits_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;

    uart_rx #(
        .DBIT     (DBIT),
        .SB_TICK  (SB_TICK),
        .DVSR     (DVSR),
        .DVSR_BIT (DVSR_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .dout      (rx_byte),
        .rx_done   (rx_done_w),
        .frame_err (ferr_w)
    );

    assign byte_c = 8'(rx_byte);
    assign hex_c  = hex_decode(byte_c);

    // Command FSM; the shadow keeps only the low 13 bits of up to four digits.
    always_comb begin
        cstate_d = cstate_q;
        stream_d = stream_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        digits_d = digits_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        case (cstate_q)
            C_IDLE: begin
                if (rx_done_w) begin
                    case (byte_c)
                        CMD_START: stream_d = 1'b1;
                        CMD_PAUSE: stream_d = 1'b0;
                        CMD_MASK: begin
                            cstate_d = C_MASK;
                            shadow_d = '0;
                            digits_d = '0;
                        end
                        CR, LF: ;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            C_MASK: begin
                if (rx_done_w) begin
                    cstate_d = C_IDLE;
                    if (hex_c.ok) begin
                        if (digits_q == DIGIT_W'(MAX_DIGITS)) begin
                            err_d = 1'b1;
                        end else begin
                            cstate_d = C_MASK;
                            shadow_d = {shadow_q[MASK_W-5:0], hex_c.val};
                            digits_d = digits_q + DIGIT_W'(1);
                        end
                    end else if (byte_c == CR && digits_q != '0) begin
                        mask_d = shadow_q;
                        ack_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (ferr_w) begin
                    cstate_d = C_IDLE;
                    err_d    = 1'b1;
                end
            end
            default: cstate_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cstate_q <= C_IDLE;
            stream_q <= 1'b0;
            mask_q   <= MASK_RESET;
            shadow_q <= '0;
            digits_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cstate_q <= cstate_d;
            stream_q <= stream_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            digits_q <= digits_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign rx_data   = rx_byte;
    assign rx_valid  = rx_done_w;
    assign frame_err = ferr_w;
    assign stream_en = stream_q;
    assign ch_mask   = mask_q;
    assign cmd_ack   = ack_q;
    assign cmd_err   = err_q;

endmodule
